// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and constants for the ALU instruction issue path
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int REG_W = 4;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] MUL  = 4'd2;
  localparam logic [3:0] SELA = 4'd3;
  localparam logic [3:0] SELB = 4'd4;
  localparam logic [3:0] AND  = 4'd5;
  localparam logic [3:0] OR   = 4'd6;
  localparam logic [3:0] XOR  = 4'd7;
  localparam logic [3:0] NEGA = 4'd8;
  localparam logic [3:0] NEGB = 4'd9;
  localparam logic [3:0] SRA  = 4'd10;
  localparam logic [3:0] SLA  = 4'd11;

  typedef struct packed {
    logic [3:0]       func;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [7:0]       addr;
  } instr_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } sb_ent_t;

endpackage

`default_nettype wire

// File: rtl/pipe_issue_fifo.sv
// ============================================================================
// pipe_issue_fifo : synchronous instr_t FIFO with flush and combinational head
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module pipe_issue_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  instr_t                     wdata_i,
  output instr_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  instr_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk1) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);

endmodule

`default_nettype wire

// File: rtl/pipe_issue.sv
// ============================================================================
// pipe_issue : in-order issue front-end with RAW scoreboard for the ALU
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module pipe_issue
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WB_LAT  = 3,
  parameter int STALL_W = 16
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_func,
  input  logic [REG_W-1:0]        in_rs1,
  input  logic [REG_W-1:0]        in_rs2,
  input  logic [REG_W-1:0]        in_rd,
  input  logic [7:0]              in_addr,
  output logic                    out_valid,
  output logic [3:0]              out_func,
  output logic [REG_W-1:0]        out_rs1,
  output logic [REG_W-1:0]        out_rs2,
  output logic [REG_W-1:0]        out_rd,
  output logic [7:0]              out_addr,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [STALL_W-1:0]      stall_cnt,
  output logic                    busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  instr_t         wdata;
  instr_t         head;
  logic [CW-1:0]  count;
  logic           full;
  logic           push;
  logic           head_valid;
  logic           hazard;
  logic           sb_any;
  logic           issue;
  logic           stall;

  instr_t               out_q;
  logic                 out_valid_q;
  logic [STALL_W-1:0]   stall_q;
  sb_ent_t              sb_q [WB_LAT];
  sb_ent_t              sb_d [WB_LAT];

  assign wdata    = '{func: in_func, rs1: in_rs1, rs2: in_rs2, rd: in_rd, addr: in_addr};
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;

  pipe_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  assign head_valid = (count != '0);

  // Both sources are compared regardless of func; rd-only matches (WAW) are ignored.
  always_comb begin
    hazard = 1'b0;
    sb_any = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (sb_q[i].v) begin
        sb_any = 1'b1;
        if (sb_q[i].rd == head.rs1 || sb_q[i].rd == head.rs2) hazard = 1'b1;
      end
    end
    hazard = hazard && head_valid;
  end

  assign issue = head_valid && !hazard && !flush;
  assign stall = head_valid && hazard;

  assign sb_d[0] = '{v: issue, rd: head.rd};
  for (genvar i = 1; i < WB_LAT; i++) begin : g_sb_shift
    assign sb_d[i] = sb_q[i-1];
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
      for (int i = 0; i < WB_LAT; i++) sb_q[i] <= '0;
    end else begin
      out_valid_q <= issue;
      if (issue) out_q <= head;
      if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
      for (int i = 0; i < WB_LAT; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_func   = out_q.func;
  assign out_rs1    = out_q.rs1;
  assign out_rs2    = out_q.rs2;
  assign out_rd     = out_q.rd;
  assign out_addr   = out_q.addr;
  assign fifo_level = count;
  assign stall_cnt  = stall_q;
  assign busy       = head_valid || sb_any;

endmodule

`default_nettype wire

// File: tb/tb_pipe_issue.sv
// ============================================================================
// tb_pipe_issue : directed vector-table bench for pipe_issue
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_pipe_issue;
  import pipe_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_func = '0, in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [7:0]  in_addr = '0;
  logic        out_valid;
  logic [3:0]  out_func, out_rs1, out_rs2, out_rd;
  logic [7:0]  out_addr;
  logic [2:0]  fifo_level;
  logic [15:0] stall_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  pipe_issue #(.DEPTH(4), .WB_LAT(3), .STALL_W(16)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_addr(in_addr),
    .out_valid(out_valid), .out_func(out_func), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_addr(out_addr),
    .fifo_level(fifo_level), .stall_cnt(stall_cnt), .busy(busy)
  );

  typedef struct {
    logic   rst;
    logic   vld;
    logic   fl;
    instr_t in;
    logic   rdy;
    logic   ov;
    instr_t out;
    int     lvl;
    int     st;
    logic   bz;
  } vec_t;

  vec_t vecs[$];

  function automatic instr_t mk(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] d, input logic [7:0] ad);
    instr_t r;
    r = '{func: f, rs1: a, rs2: b, rd: d, addr: ad};
    return r;
  endfunction

  function automatic vec_t mv(input logic rst, input logic vld, input logic fl, input instr_t in,
                              input logic rdy, input logic ov, input instr_t out,
                              input int lvl, input int st, input logic bz);
    vec_t v;
    v = '{rst: rst, vld: vld, fl: fl, in: in, rdy: rdy, ov: ov, out: out, lvl: lvl, st: st, bz: bz};
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input instr_t o,
                            input int lvl, input int st, input logic bz);
    instr_t cur;
    cur = '{func: out_func, rs1: out_rs1, rs2: out_rs2, rd: out_rd, addr: out_addr};
    chk({tag, " out_valid"},  {31'd0, out_valid}, {31'd0, ov});
    chk({tag, " out_fields"}, {8'd0, cur}, {8'd0, o});
    chk({tag, " fifo_level"}, {29'd0, fifo_level}, lvl);
    chk({tag, " stall_cnt"},  {16'd0, stall_cnt}, st);
    chk({tag, " busy"},       {31'd0, busy}, {31'd0, bz});
  endtask

  task automatic step(input logic vld, input logic fl, input instr_t ins, output logic rdy);
    @(negedge clk1);
    in_valid = vld;
    flush    = fl;
    {in_func, in_rs1, in_rs2, in_rd, in_addr} = ins;
    #1 rdy = in_ready;
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t Z, A, M, X, S, P1, P2, P3, X0, Y1, Y2, Y3, Y4, Y5, B, C, D, E, F, G;
    instr_t exp_q[$];
    logic   r;

    Z  = '0;
    A  = mk(ADD, 4'd3, 4'd5, 4'd10, 8'd125);
    M  = mk(MUL, 4'd3, 4'd8, 4'd12, 8'd126);
    X  = mk(XOR, 4'd7, 4'd3, 4'd13, 8'd127);
    S  = mk(SUB, 4'd10, 4'd5, 4'd14, 8'd128);
    P1 = mk(ADD, 4'd1, 4'd2, 4'd12, 8'h10);
    P2 = mk(ADD, 4'd1, 4'd12, 4'd15, 8'h11);
    P3 = mk(MUL, 4'd2, 4'd3, 4'd4, 8'h12);

    // independent stream
    vecs.push_back(mv(1, 1, 0, A, 1, 0, Z, 1, 0, 1));
    vecs.push_back(mv(0, 1, 0, M, 1, 1, A, 1, 0, 1));
    vecs.push_back(mv(0, 1, 0, X, 1, 1, M, 1, 0, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 1, X, 0, 0, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, X, 0, 0, 1));
    // RAW on rs1: three bubbles, then scoreboard drains
    vecs.push_back(mv(1, 1, 0, A, 1, 0, Z, 1, 0, 1));
    vecs.push_back(mv(0, 1, 0, S, 1, 1, A, 1, 0, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, A, 1, 1, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, A, 1, 2, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, A, 1, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 1, S, 0, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, S, 0, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, S, 0, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z, 1, 0, S, 0, 3, 0));
    // RAW on rs2, younger independent entry waits in order
    vecs.push_back(mv(1, 1, 0, P1, 1, 0, Z,  1, 0, 1));
    vecs.push_back(mv(0, 1, 0, P2, 1, 1, P1, 1, 0, 1));
    vecs.push_back(mv(0, 1, 0, P3, 1, 0, P1, 2, 1, 1));
    vecs.push_back(mv(0, 0, 0, Z,  1, 0, P1, 2, 2, 1));
    vecs.push_back(mv(0, 0, 0, Z,  1, 0, P1, 2, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z,  1, 1, P2, 1, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z,  1, 1, P3, 0, 3, 1));
    vecs.push_back(mv(0, 0, 0, Z,  1, 0, P3, 0, 3, 1));

    // reset state, with a push attempted while in reset
    in_valid = 1'b1;
    {in_func, in_rs1, in_rs2, in_rd, in_addr} = A;
    repeat (2) @(posedge clk1);
    #1;
    check_outs("reset", 0, Z, 0, 0, 0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].vld, vecs[i].fl, vecs[i].in, r);
      chk($sformatf("vec%0d in_ready", i), {31'd0, r}, {31'd0, vecs[i].rdy});
      check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].out, vecs[i].lvl, vecs[i].st, vecs[i].bz);
    end

    // full FIFO behind a stalled head
    do_reset();
    X0 = mk(ADD, 4'd1, 4'd2, 4'd9, 8'h40);
    Y1 = mk(SUB, 4'd9, 4'd0, 4'd1, 8'h41);
    Y2 = mk(OR,  4'd0, 4'd0, 4'd2, 8'h42);
    Y3 = mk(OR,  4'd0, 4'd0, 4'd3, 8'h43);
    Y4 = mk(OR,  4'd0, 4'd0, 4'd4, 8'h44);
    Y5 = mk(OR,  4'd0, 4'd0, 4'd5, 8'h45);
    step(1, 0, X0, r); check_outs("full0", 0, Z,  1, 0, 1);
    step(1, 0, Y1, r); check_outs("full1", 1, X0, 1, 0, 1);
    step(1, 0, Y2, r); check_outs("full2", 0, X0, 2, 1, 1);
    step(1, 0, Y3, r); check_outs("full3", 0, X0, 3, 2, 1);
    step(1, 0, Y4, r); check_outs("full4", 0, X0, 4, 3, 1);
    chk("full4 in_ready", {31'd0, r}, 32'd1);
    step(1, 0, Y5, r);
    chk("full5 in_ready", {31'd0, r}, 32'd0);
    check_outs("full5", 1, Y1, 3, 3, 1);
    step(1, 0, Y5, r);
    chk("full6 in_ready", {31'd0, r}, 32'd1);
    check_outs("full6", 1, Y2, 3, 3, 1);
    exp_q = '{Y3, Y4, Y5};
    for (int k = 0; k < 3; k++) begin
      step(0, 0, Z, r);
      check_outs($sformatf("drain%0d", k), 1, exp_q[k], 2 - k, 3, 1);
    end
    step(0, 0, Z, r); check_outs("drain_end", 0, Y5, 0, 3, 1);

    // flush of three queued entries, then flush right after an issue
    do_reset();
    A = mk(ADD, 4'd1, 4'd2, 4'd10, 8'h20);
    B = mk(SUB, 4'd10, 4'd1, 4'd3, 8'h21);
    C = mk(AND, 4'd10, 4'd2, 4'd5, 8'h22);
    D = mk(OR,  4'd4, 4'd10, 4'd6, 8'h23);
    E = mk(XOR, 4'd7, 4'd7, 4'd11, 8'h30);
    F = mk(NEGA, 4'd1, 4'd0, 4'd12, 8'h31);
    G = mk(SRA, 4'd2, 4'd2, 4'd13, 8'h32);
    step(1, 0, A, r); check_outs("fl0", 0, Z, 1, 0, 1);
    step(1, 0, B, r); check_outs("fl1", 1, A, 1, 0, 1);
    step(1, 0, C, r); check_outs("fl2", 0, A, 2, 1, 1);
    step(1, 0, D, r); check_outs("fl3", 0, A, 3, 2, 1);
    step(0, 0, Z, r); check_outs("fl4", 0, A, 3, 3, 1);
    step(0, 1, Z, r); check_outs("fl5", 0, A, 0, 3, 0);
    step(1, 0, E, r); check_outs("fl6", 0, A, 1, 3, 1);
    step(1, 0, F, r); check_outs("fl7", 1, E, 1, 3, 1);
    step(1, 1, G, r); check_outs("fl8", 0, E, 0, 3, 1);
    step(0, 0, Z, r); check_outs("fl9", 0, E, 0, 3, 1);
    step(0, 0, Z, r); check_outs("fl10", 0, E, 0, 3, 0);

    // asynchronous reset while stalled
    do_reset();
    A = mk(ADD, 4'd3, 4'd5, 4'd10, 8'd125);
    step(1, 0, A, r); check_outs("ar0", 0, Z, 1, 0, 1);
    step(1, 0, S, r); check_outs("ar1", 1, A, 1, 0, 1);
    step(0, 0, Z, r); check_outs("ar2", 0, A, 1, 1, 1);
    @(negedge clk1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    check_outs("ar_async", 0, Z, 0, 0, 0);
    @(posedge clk1);
    #1;
    check_outs("ar_held", 0, Z, 0, 0, 0);
    @(negedge clk1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1, 0, A, r); check_outs("ar3", 0, Z, 1, 0, 1);
    step(0, 0, Z, r); check_outs("ar4", 1, A, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
